// File: rtl/barrier_control_if.sv
// barrier_control_if: command and arm-status bundle between the parking controller and the barrier block
interface barrier_control_if;
  logic       open_entry;
  logic       open_exit;
  logic       close_entry;
  logic       close_exit;
  logic       emergency;
  logic       vehicle_direction;
  logic       entry_barrier;
  logic       exit_barrier;
  logic [1:0] barrier_status;
  modport master (
    output open_entry, open_exit, close_entry, close_exit, emergency, vehicle_direction,
    input  entry_barrier, exit_barrier, barrier_status
  );
  modport slave (
    input  open_entry, open_exit, close_entry, close_exit, emergency, vehicle_direction,
    output entry_barrier, exit_barrier, barrier_status
  );
endinterface

// File: rtl/barrier_control.sv
// barrier_control: timed open/close sequencing of the entry and exit arms; DIRECTION_INTERLOCK_EN gates opens by vehicle_direction
module barrier_control #(
  parameter int BARRIER_DELAY = 10
) (
  input logic clk,
  input logic reset,
  barrier_control_if.slave bus
);
  localparam int W = $clog2(BARRIER_DELAY + 1);
  localparam logic [W-1:0] OPEN_LOAD = W'(BARRIER_DELAY - 1);
  localparam logic [W-1:0] CLOSE_LOAD = W'(BARRIER_DELAY / 2 - 1);
  // encoding is {opening, closing, barrier}; ABORTING is a close that started before the arm was up
  typedef enum logic [2:0] {
    CLOSED   = 3'b000,
    OPENING  = 3'b100,
    OPEN     = 3'b001,
    CLOSING  = 3'b011,
    ABORTING = 3'b010
  } arm_state_t;
  arm_state_t st [2];
  arm_state_t st_n [2];
  logic [W-1:0] cnt [2];
  logic [W-1:0] cnt_n [2];
  logic [1:0] open_req;
  logic [1:0] close_req;
  logic entry_opening, entry_closing, entry_barrier;
  logic exit_opening, exit_closing, exit_barrier;
  assign close_req = {bus.close_exit, bus.close_entry};
`ifdef DIRECTION_INTERLOCK_EN
  assign open_req = {bus.open_exit & bus.vehicle_direction, bus.open_entry & ~bus.vehicle_direction};
`else
  assign open_req = {bus.open_exit, bus.open_entry};
`endif
  assign {entry_opening, entry_closing, entry_barrier} = st[0];
  assign {exit_opening, exit_closing, exit_barrier} = st[1];
  assign bus.entry_barrier = entry_barrier;
  assign bus.exit_barrier = exit_barrier;
  assign bus.barrier_status = {exit_barrier, entry_barrier};
  // per-arm next state: emergency overrides everything, close beats open
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      st_n[i] = st[i];
      cnt_n[i] = cnt[i];
      if (bus.emergency) begin
        st_n[i] = OPEN;
        cnt_n[i] = '0;
      end else begin
        case (st[i])
          CLOSED: if (open_req[i] && !close_req[i]) begin
            st_n[i] = OPENING;
            cnt_n[i] = OPEN_LOAD;
          end
          OPENING: if (close_req[i]) begin
            st_n[i] = ABORTING;
            cnt_n[i] = CLOSE_LOAD;
          end else if (cnt[i] == '0) st_n[i] = OPEN;
          else cnt_n[i] = cnt[i] - W'(1);
          OPEN: if (close_req[i]) begin
            st_n[i] = CLOSING;
            cnt_n[i] = CLOSE_LOAD;
          end
          CLOSING, ABORTING: if (cnt[i] == '0) st_n[i] = CLOSED;
          else cnt_n[i] = cnt[i] - W'(1);
          default: begin
            st_n[i] = CLOSED;
            cnt_n[i] = '0;
          end
        endcase
      end
    end
  end
  // arm state and timers; reset aborts any sequence and leaves both arms closed
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      st[i] <= !reset ? CLOSED : st_n[i];
      cnt[i] <= !reset ? '0 : cnt_n[i];
    end
  end
endmodule

// File: tb/tb_barrier_control.sv
// tb_barrier_control: directed and random stimulus checked against a countdown model of both arms
module tb_barrier_control;
  localparam int D = 10;
`ifdef DIRECTION_INTERLOCK_EN
  localparam logic [1:0] BOTH_OPEN = 2'b01;
`else
  localparam logic [1:0] BOTH_OPEN = 2'b11;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  int rem_open [2];
  int rem_close [2];
  logic bar [2];
  int emg_left = 0;
  barrier_control_if bus ();
  barrier_control #(.BARRIER_DELAY(D)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(string tag, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_update();
    logic [1:0] op;
    logic [1:0] cl;
    op = {bus.open_exit, bus.open_entry};
    cl = {bus.close_exit, bus.close_entry};
`ifdef DIRECTION_INTERLOCK_EN
    op = op & (bus.vehicle_direction ? 2'b10 : 2'b01);
`endif
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        rem_open[i] = 0;
        rem_close[i] = 0;
        bar[i] = 1'b0;
      end else if (bus.emergency) begin
        rem_open[i] = 0;
        rem_close[i] = 0;
        bar[i] = 1'b1;
      end else if (rem_open[i] > 0) begin
        if (cl[i]) begin
          rem_open[i] = 0;
          rem_close[i] = D / 2;
        end else begin
          rem_open[i]--;
          if (rem_open[i] == 0) bar[i] = 1'b1;
        end
      end else if (rem_close[i] > 0) begin
        rem_close[i]--;
        if (rem_close[i] == 0) bar[i] = 1'b0;
      end else if (bar[i]) begin
        if (cl[i]) rem_close[i] = D / 2;
      end else if (op[i] && !cl[i]) begin
        rem_open[i] = D;
      end
    end
  endtask
  task automatic tick(string tag);
    @(posedge clk);
    model_update();
    #1;
    check(tag,
      {dut.exit_opening, dut.entry_opening, dut.exit_closing, dut.entry_closing,
       bus.exit_barrier, bus.entry_barrier, bus.barrier_status},
      {rem_open[1] > 0, rem_open[0] > 0, rem_close[1] > 0, rem_close[0] > 0,
       bar[1], bar[0], bar[1], bar[0]});
  endtask
  task automatic run(int n, string tag);
    for (int k = 0; k < n; k++) tick(tag);
  endtask
  task automatic cmd(logic oe, logic ox, logic ce, logic cx, string tag);
    bus.open_entry = oe;
    bus.open_exit = ox;
    bus.close_entry = ce;
    bus.close_exit = cx;
    tick(tag);
    bus.open_entry = 1'b0;
    bus.open_exit = 1'b0;
    bus.close_entry = 1'b0;
    bus.close_exit = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      rem_open[i] = 0;
      rem_close[i] = 0;
      bar[i] = 1'b0;
    end
    bus.open_entry = 1'b0;
    bus.open_exit = 1'b0;
    bus.close_entry = 1'b0;
    bus.close_exit = 1'b0;
    bus.emergency = 1'b0;
    bus.vehicle_direction = 1'b0;
    run(2, "reset");
    check("reset_status", 8'(bus.barrier_status), 8'h00);
    check("reset_flags", 8'({dut.entry_opening, dut.exit_opening, dut.entry_closing, dut.exit_closing}), 8'h00);
    reset = 1'b1;
    cmd(1, 0, 0, 0, "open_entry");
    run(9, "opening");
    check("opening_hold", 8'({dut.entry_opening, bus.barrier_status}), 8'b100);
    tick("opened");
    check("entry_open", 8'(bus.barrier_status), 8'h01);
    cmd(0, 0, 1, 0, "close_entry");
    run(4, "closing");
    check("closing_hold", 8'({dut.entry_closing, bus.barrier_status}), 8'b101);
    tick("closed");
    check("entry_closed", 8'(bus.barrier_status), 8'h00);
    bus.emergency = 1'b1;
    tick("emergency");
    check("emg_open", 8'(bus.barrier_status), 8'h03);
    run(4, "emergency_hold");
    bus.emergency = 1'b0;
    run(3, "emg_release");
    check("emg_stays_open", 8'(bus.barrier_status), 8'h03);
    cmd(0, 0, 1, 1, "close_both");
    run(4, "closing_both");
    check("both_closing", 8'(bus.barrier_status), 8'h03);
    tick("closed_both");
    check("emg_closed", 8'(bus.barrier_status), 8'h00);
    cmd(1, 1, 0, 0, "open_both");
    run(9, "opening_both");
    tick("opened_both");
    check("both_open", 8'(bus.barrier_status), 8'(BOTH_OPEN));
    cmd(0, 0, 1, 1, "close_both2");
    run(5, "closing_both2");
    check("both_closed", 8'(bus.barrier_status), 8'h00);
    cmd(1, 0, 0, 0, "open_abort");
    run(4, "opening_abort");
    cmd(0, 0, 1, 0, "abort");
    run(4, "aborting");
    check("abort_hold", 8'({dut.entry_closing, dut.entry_opening, bus.entry_barrier}), 8'b100);
    tick("aborted");
    check("abort_closed", 8'(bus.barrier_status), 8'h00);
    cmd(1, 0, 1, 0, "open_close_same");
    check("close_wins", 8'({dut.entry_opening, bus.barrier_status}), 8'h00);
    cmd(1, 1, 0, 0, "open_mid_reset");
    run(3, "opening_mid_reset");
    reset = 1'b0;
    run(2, "mid_reset");
    check("mid_reset_status", 8'(bus.barrier_status), 8'h00);
    check("mid_reset_flags", 8'({dut.entry_opening, dut.exit_opening, dut.entry_closing, dut.exit_closing}), 8'h00);
    reset = 1'b1;
    cmd(1, 0, 0, 0, "reopen");
    run(9, "reopening");
    tick("reopened");
    check("reopen_done", 8'(bus.barrier_status), 8'h01);
    for (int n = 0; n < 4000; n++) begin
      bus.open_entry = ($urandom_range(0, 7) == 0);
      bus.open_exit = ($urandom_range(0, 7) == 0);
      bus.close_entry = ($urandom_range(0, 11) == 0);
      bus.close_exit = ($urandom_range(0, 11) == 0);
      bus.vehicle_direction = 1'($urandom_range(0, 1));
      if (emg_left > 0) emg_left--;
      else if ($urandom_range(0, 99) == 0) emg_left = int'($urandom_range(1, 5));
      bus.emergency = (emg_left > 0);
      reset = !($urandom_range(0, 199) == 0);
      tick("random");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
